// File: rtl/cbus_ram_responder_pkg.sv
// Shared CBUS types: request/response structs, burst length type and burst encodings.
package cbus_ram_responder_pkg;

    localparam int CBUS_BEAT_BYTES = 8;

    typedef logic [7:0] mlen_t;
    typedef logic [1:0] cbus_burst_t;

    // WRAP is carried on the bus but this responder walks it like INCR.
    localparam cbus_burst_t CBUS_BURST_FIXED = 2'd0;
    localparam cbus_burst_t CBUS_BURST_INCR  = 2'd1;
    localparam cbus_burst_t CBUS_BURST_WRAP  = 2'd2;

    typedef struct packed {
        logic                       valid;
        logic                       is_write;
        logic [2:0]                 size;
        logic [63:0]                addr;
        logic [CBUS_BEAT_BYTES-1:0] strobe;
        logic [63:0]                data;
        mlen_t                      len;
        cbus_burst_t                burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_ram_array.sv
// Single-port 64-bit word array: synchronous read, per-byte write enables, no reset on contents.
module cbus_ram_array #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    be,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cbus_ram_responder.sv
// CBUS memory responder: accepts one burst in IDLE, waits LATENCY cycles, then streams one beat per cycle.
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  oreq,
    output cbus_resp_t oresp,
    output logic [1:0] dbg_state
);

    // Handshake: a request is taken on a clock edge in IDLE with oreq.valid=1; every cycle with
    // oresp.ready=1 is exactly one beat (writes consume oreq.data/strobe that cycle), last marks beat len.

    localparam int         AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] WAIT_END = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t      state;
    logic [3:0]  lat_cnt;
    mlen_t       beat_q;
    mlen_t       len_q;
    logic        is_write_q;
    logic [63:0] addr_q;
    cbus_burst_t burst_q;
    logic        ready_q;
    logic        last_q;
    logic        rd_ok_q;

    logic [63:0] cur_idx;
    logic [63:0] fetch_idx;
    logic        cur_ok;
    logic        fetch_ok;
    logic        arr_we;
    logic [AW-1:0] arr_addr;
    logic [63:0] rdata;
    logic        unused_size;

    assign unused_size = ^oreq.size;
    assign dbg_state   = state;

    function automatic logic [63:0] beat_index(input logic [63:0] addr, input cbus_burst_t burst,
                                               input mlen_t beat);
        logic [63:0] word;
        word = (addr - BASE_ADDR) >> 3;
        return (burst == CBUS_BURST_FIXED) ? word : word + 64'(beat);
    endfunction

    // Reads are fetched one beat ahead; writes address the beat currently on the bus.
    always_comb begin
        cur_idx = beat_index(addr_q, burst_q, beat_q);
        if (state == IDLE)
            fetch_idx = beat_index(oreq.addr, oreq.burst, '0);
        else if (state == BURST)
            fetch_idx = beat_index(addr_q, burst_q, beat_q + 8'd1);
        else
            fetch_idx = beat_index(addr_q, burst_q, '0);
        cur_ok   = cur_idx < 64'(MEM_WORDS);
        fetch_ok = fetch_idx < 64'(MEM_WORDS);
        arr_we   = ready_q && is_write_q && cur_ok;
        arr_addr = (state == BURST && is_write_q) ? cur_idx[AW-1:0] : fetch_idx[AW-1:0];

        oresp       = '0;
        oresp.ready = ready_q;
        oresp.last  = last_q;
        oresp.data  = (ready_q && !is_write_q && rd_ok_q) ? rdata : 64'h0;
    end

    cbus_ram_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .be    (oreq.strobe),
        .wdata (oreq.data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            burst_q    <= CBUS_BURST_INCR;
            ready_q    <= 1'b0;
            last_q     <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            rd_ok_q <= fetch_ok;
            case (state)
                IDLE: begin
                    if (oreq.valid) begin
                        is_write_q <= oreq.is_write;
                        addr_q     <= oreq.addr;
                        len_q      <= oreq.len;
                        burst_q    <= oreq.burst;
                        beat_q     <= '0;
                        lat_cnt    <= '0;
                        // With a one-cycle latency the first beat must follow acceptance directly.
                        if (LATENCY <= 1) begin
                            state   <= BURST;
                            ready_q <= 1'b1;
                            last_q  <= (oreq.len == '0);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == WAIT_END) begin
                        state   <= BURST;
                        ready_q <= 1'b1;
                        last_q  <= (len_q == '0);
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                BURST: begin
                    if (beat_q == len_q) begin
                        state   <= DONE;
                        ready_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        beat_q <= beat_q + 8'd1;
                        last_q <= ((beat_q + 8'd1) == len_q);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder: table of bursts with hand-computed beat data plus a mid-burst reset sequence.
module tb_cbus_ram_responder;
    import cbus_ram_responder_pkg::*;

    localparam int          MEM_WORDS = 64;
    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int          LATENCY   = 2;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic             w;
        cbus_burst_t      burst;
        int               word;
        logic [2:0]       lo;
        mlen_t            len;
        logic [7:0]       strobe;
        logic [63:0]      wbase;
        logic [3:0][63:0] exp;
    } vec_t;

    vec_t tbl [22];

    always #5 clk = ~clk;

    cbus_ram_responder #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .oreq      (oreq),
        .oresp     (oresp),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic w, input cbus_burst_t b, input int word, input logic [2:0] lo,
                                input mlen_t len, input logic [7:0] strobe, input logic [63:0] wbase,
                                input logic [63:0] e0, input logic [63:0] e1,
                                input logic [63:0] e2, input logic [63:0] e3);
        vec_t v;
        v.w = w; v.burst = b; v.word = word; v.lo = lo; v.len = len;
        v.strobe = strobe; v.wbase = wbase;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    function automatic logic [63:0] word_addr(input int word, input logic [2:0] lo);
        longint off;
        off = longint'(word) * 64'sd8;
        return BASE + 64'(off) + {61'd0, lo};
    endfunction

    // Drives one request, then follows it beat by beat, popping exp_q for each beat's data.
    // abort_at > 0 pulses reset right after the clock edge that completes that many beats.
    task automatic run_txn(input string name, input logic w, input cbus_burst_t burst,
                           input logic [63:0] addr, input mlen_t len, input logic [7:0] strobe,
                           input logic [63:0] wbase, input int abort_at);
        int beat;
        bit done;
        bit gap;
        logic [63:0] want;
        @(negedge clk);
        oreq.valid = 1'b1; oreq.is_write = w; oreq.size = 3'd3; oreq.addr = addr;
        oreq.len = len; oreq.burst = burst; oreq.strobe = strobe; oreq.data = wbase;
        beat = 0; done = 0; gap = 0;
        for (int c = 1; c <= 64 && !done; c++) begin
            @(negedge clk);
            if (c == 1) oreq.valid = 1'b0;
            if (oresp.ready) begin
                if (beat == 0) check({name, " latency"}, 64'(c), 64'(LATENCY));
                oreq.data = wbase + 64'(beat);
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
                check({name, " data"}, oresp.data, want);
                check({name, " last"}, 64'(oresp.last), 64'(beat == int'(len)));
                if (beat == int'(len)) done = 1;
                beat++;
                if (beat == abort_at) begin
                    @(posedge clk);
                    #1 reset = 1'b0;
                    #1;
                    check({name, " reset ready"}, 64'(oresp.ready), 64'd0);
                    check({name, " reset last"}, 64'(oresp.last), 64'd0);
                    check({name, " reset data"}, oresp.data, 64'd0);
                    check({name, " reset state"}, 64'(dbg_state), 64'd0);
                    exp_q.delete();
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
            end else if (beat > 0) begin
                check({name, " ready gap"}, 64'(oresp.ready), 64'd1);
                gap = 1;
                done = 1;
            end
        end
        if (!done) check({name, " timeout beats"}, 64'(beat), 64'(len) + 64'd1);
        if (done && !gap) begin
            @(negedge clk);
            check({name, " done ready"}, 64'(oresp.ready), 64'd0);
            check({name, " done data"}, oresp.data, 64'd0);
            check({name, " done state"}, 64'(dbg_state), 64'd3);
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        oreq  = '0;
        repeat (3) @(negedge clk);
        check("rst ready", 64'(oresp.ready), 64'd0);
        check("rst last", 64'(oresp.last), 64'd0);
        check("rst data", oresp.data, 64'd0);
        check("rst state", 64'(dbg_state), 64'd0);
        reset = 1'b1;

        tbl[0]  = mk(1, CBUS_BURST_INCR, 0, 0, 0, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 0, 0);
        tbl[1]  = mk(0, CBUS_BURST_INCR, 0, 5, 0, 8'hFF, 0, 64'h1122_3344_5566_7788, 0, 0, 0);
        tbl[2]  = mk(1, CBUS_BURST_INCR, 1, 0, 3, 8'hFF, 64'd1, 0, 0, 0, 0);
        tbl[3]  = mk(0, CBUS_BURST_INCR, 1, 0, 3, 8'hFF, 0, 64'd1, 64'd2, 64'd3, 64'd4);
        tbl[4]  = mk(1, CBUS_BURST_INCR, 10, 0, 0, 8'hFF, 64'h0, 0, 0, 0, 0);
        tbl[5]  = mk(1, CBUS_BURST_INCR, 10, 0, 0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        tbl[6]  = mk(0, CBUS_BURST_INCR, 10, 0, 0, 8'hFF, 0, 64'h0000_0000_FFFF_FFFF, 0, 0, 0);
        tbl[7]  = mk(1, CBUS_BURST_INCR, 11, 0, 0, 8'hFF, 64'h0, 0, 0, 0, 0);
        tbl[8]  = mk(1, CBUS_BURST_INCR, 11, 0, 0, 8'hA5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        tbl[9]  = mk(0, CBUS_BURST_INCR, 11, 0, 0, 8'hFF, 0, 64'hFF00_FF00_00FF_00FF, 0, 0, 0);
        tbl[10] = mk(1, CBUS_BURST_INCR, 5, 0, 0, 8'hFF, 64'hAB, 0, 0, 0, 0);
        tbl[11] = mk(0, CBUS_BURST_FIXED, 5, 0, 3, 8'hFF, 0, 64'hAB, 64'hAB, 64'hAB, 64'hAB);
        tbl[12] = mk(1, CBUS_BURST_FIXED, 20, 0, 2, 8'hFF, 64'd7, 0, 0, 0, 0);
        tbl[13] = mk(0, CBUS_BURST_INCR, 20, 0, 0, 8'hFF, 0, 64'd9, 0, 0, 0);
        tbl[14] = mk(1, CBUS_BURST_INCR, MEM_WORDS - 1, 0, 0, 8'hFF, 64'h55, 0, 0, 0, 0);
        tbl[15] = mk(0, CBUS_BURST_INCR, MEM_WORDS - 1, 0, 1, 8'hFF, 0, 64'h55, 64'h0, 0, 0);
        tbl[16] = mk(1, CBUS_BURST_INCR, MEM_WORDS - 1, 0, 1, 8'hFF, 64'h77, 0, 0, 0, 0);
        tbl[17] = mk(1, CBUS_BURST_INCR, -1, 0, 1, 8'hFF, 64'hDEAD, 0, 0, 0, 0);
        tbl[18] = mk(0, CBUS_BURST_INCR, 0, 0, 1, 8'hFF, 0, 64'h1122_3344_5566_7788, 64'd1, 0, 0);
        tbl[19] = mk(0, CBUS_BURST_INCR, MEM_WORDS - 1, 0, 0, 8'hFF, 0, 64'h77, 0, 0, 0);
        tbl[20] = mk(1, CBUS_BURST_INCR, 30, 0, 7, 8'hFF, 64'hC0, 0, 0, 0, 0);
        tbl[21] = mk(0, CBUS_BURST_INCR, 30, 0, 3, 8'hFF, 0, 64'hC0, 64'hC1, 64'hC2, 64'hC3);

        for (int i = 0; i < 22; i++) begin
            exp_q.delete();
            for (int b = 0; b <= int'(tbl[i].len); b++) begin
                if (tbl[i].w) exp_q.push_back(64'h0);
                else          exp_q.push_back(tbl[i].exp[b]);
            end
            run_txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].burst, word_addr(tbl[i].word, tbl[i].lo),
                    tbl[i].len, tbl[i].strobe, tbl[i].wbase, -1);
        end

        // Reset after beat 1 of an 8-beat write: words 30,31 take new data, 32..37 keep C2..C7.
        for (int b = 0; b < 8; b++) exp_q.push_back(64'h0);
        run_txn("abort wr", 1, CBUS_BURST_INCR, word_addr(30, 0), 8'd7, 8'hFF, 64'h100, 2);
        exp_q.delete();
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h101);
        for (int b = 2; b < 8; b++) exp_q.push_back(64'hC0 + 64'(b));
        run_txn("after rst rd", 0, CBUS_BURST_INCR, word_addr(30, 0), 8'd7, 8'hFF, 64'h0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cbus_ram_responder.md
CBUS_RAM_RESPONDER -- requirements
Module: cbus_ram_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, giving the 64-bit word count of the backing array.
REQ-002 SHALL have parameter BASE_ADDR, default 64'h8000_0000, giving the byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, giving cycles from request acceptance to the first beat; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port oreq, input, cbus_req_t: fields valid, is_write, size, addr, strobe, data, len, burst.
REQ-007 SHALL have port oresp, output, cbus_resp_t: fields ready, last, data.

Function
REQ-008 SHALL implement states IDLE, WAIT, BURST and DONE.
REQ-009 In IDLE, SHALL accept the request when oreq.valid=1: latch is_write, addr, len and burst, clear the beat counter and the latency counter, and go to WAIT.
REQ-010 In WAIT, SHALL count LATENCY-1 further cycles, then go to BURST, so the first ready is exactly LATENCY cycles after the acceptance cycle.
REQ-011 In BURST, SHALL assert oresp.ready=1 every cycle with one beat per cycle, and assert oresp.last=1 on beat index == len (len is encoded as beats-1).
REQ-012 After the last beat, SHALL spend one cycle in DONE with ready=0, ignoring oreq.valid, then return to IDLE.
REQ-013 Beat word index: INCR = ((addr-BASE_ADDR)>>3)+beat, with 64-bit subtraction; FIXED = (addr-BASE_ADDR)>>3 for all beats.
REQ-014 SHALL ignore addr[2:0] for indexing; size does not alter beat count or indexing.
REQ-015 Read beat: oresp.data SHALL equal the array word at the beat index, fetched one cycle earlier through the synchronous read port.
REQ-016 Write beat: on each ready cycle, SHALL write oreq.data into the indexed word, byte i only where oreq.strobe[i]=1; oresp.data SHALL be 0.
REQ-017 Out-of-range beat (index >= MEM_WORDS, including wrap-around past the top of the array): read SHALL return 64'h0, write SHALL be dropped, and the handshake SHALL still complete normally.
REQ-018 A read beat that follows a write to the same word SHALL return the written data; only ordering between transactions applies, since there is no intra-burst read/write mix.
REQ-019 oresp.ready and oresp.last SHALL be 0 in IDLE, WAIT and DONE; oresp.data SHALL be 0 whenever ready=0.
REQ-020 If oreq.valid drops mid-transaction (protocol violation), SHALL complete the burst anyway; writes use whatever data and strobe are present.

Reset
REQ-021 On reset=0, SHALL asynchronously force state IDLE, both counters to 0, and oresp to all zeros.
REQ-022 Reset SHALL NOT clear array contents.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; beats already written remain.
REQ-024 After reset deasserts, SHALL accept a new request in the first cycle with valid=1.

Structure
REQ-025 SHALL use cbus_req_t, cbus_resp_t, mlen_t and the burst encodings from the shared common package.
REQ-026 SHALL keep the state enum local to the module.
REQ-027 The shared common package SHALL additionally hold the constant CBUS_BEAT_BYTES=8.
REQ-028 SHALL instantiate one sub-module, cbus_ram_array: single port, MEM_WORDS x 64, synchronous read, byte-enable write.
REQ-029 Target implementation size SHALL be about 200 RTL lines.

Verification
REQ-030 Single read: preload word 0 = 64'h1122_3344_5566_7788; read BASE_ADDR, len=0 -> one ready with last=1 and data=64'h1122_3344_5566_7788, exactly 2 cycles after acceptance (LATENCY=2).
REQ-031 INCR write burst: len=3 at BASE_ADDR+8, data 1,2,3,4, strobe 8'hFF -> 4 consecutive ready cycles, last on the 4th; words 1..4 = 1..4.
REQ-032 Strobed write then read: write 64'hFFFF_FFFF_FFFF_FFFF over 64'h0, strobe 8'h0F -> readback 64'h0000_0000_FFFF_FFFF.
REQ-033 FIXED read: len=3 at word 5 (value 64'hAB) -> 4 beats, each with data 64'hAB.
REQ-034 Out of range: INCR read len=1 starting at word MEM_WORDS-1 -> beat 0 returns the array value, beat 1 returns 0, last asserted; a write to BASE_ADDR-8 leaves all words unchanged.
REQ-035 Reset mid-burst: assert reset after beat 1 of a len=7 write -> ready=0 immediately; words 0..1 written, words 2..7 unchanged; the next read completes normally.
